// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction controller and the ALU.
// Contents: instruction field widths, opcode/funcA/funcB encodings, the
// controller FSM state enum, and a funcA write-back helper.
package cpu_pkg;

   localparam int unsigned InstrW   = 9;
   localparam int unsigned PcW      = 8;
   localparam int unsigned OpW      = 3;
   localparam int unsigned FuncAW   = 3;
   localparam int unsigned RegAddrW = 3;
   localparam int unsigned OffsetW  = 5;

   localparam logic [OpW-1:0] OpLoad   = 3'b000;
   localparam logic [OpW-1:0] OpStore  = 3'b001;
   localparam logic [OpW-1:0] OpAdd    = 3'b010;
   localparam logic [OpW-1:0] OpAlu3   = 3'b011;
   localparam logic [OpW-1:0] OpAlu4   = 3'b100;
   localparam logic [OpW-1:0] OpDist   = 3'b101;
   localparam logic [OpW-1:0] OpFunc   = 3'b110;
   localparam logic [OpW-1:0] OpBranch = 3'b111;
   // The ALU leaves its overflow flag untouched when it sees this opcode.
   localparam logic [OpW-1:0] OpHold   = 3'b111;

   localparam logic [FuncAW-1:0] FuncA0    = 3'b000;
   localparam logic [FuncAW-1:0] FuncA1    = 3'b001;
   localparam logic [FuncAW-1:0] FuncA2    = 3'b010;
   localparam logic [FuncAW-1:0] FuncA3    = 3'b011;
   localparam logic [FuncAW-1:0] FuncA4    = 3'b100;
   localparam logic [FuncAW-1:0] FuncA5    = 3'b101;
   localparam logic [FuncAW-1:0] FuncARsvd = 3'b110;
   localparam logic [FuncAW-1:0] FuncAHalt = 3'b111;

   localparam logic FuncBOvfClr = 1'b0;
   localparam logic FuncBOvfSet = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StMem,
      StHalted
   } state_e;

   // funcA operations of opcode 110 that write a register result.
   function automatic logic funca_writes(input logic [FuncAW-1:0] fa);
      logic w;
      case (fa)
         FuncA0, FuncA1, FuncA2, FuncA5: w = 1'b1;
         default:                        w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next program counter.
// Ports:
//   i_pc      current PC
//   i_offset  signed 5-bit branch offset
//   i_branch  1 = PC + sign-extended offset, 0 = PC + 1
//   o_pc_next next PC, wrapping modulo 256
module pc_next
   import cpu_pkg::*;
(
   input  logic [PcW-1:0]     i_pc,
   input  logic [OffsetW-1:0] i_offset,
   input  logic               i_branch,
   output logic [PcW-1:0]     o_pc_next
);

   logic [PcW-1:0] w_offset_ext;

   assign w_offset_ext = {{(PcW-OffsetW){i_offset[OffsetW-1]}}, i_offset};

   // Additions are truncated to PcW bits, giving the modulo-256 wrap.
   always_comb begin
      if (i_branch) o_pc_next = i_pc + w_offset_ext;
      else          o_pc_next = i_pc + PcW'(1);
   end

endmodule

// File: rtl/instr_ctrl.sv
// instr_ctrl: multi-cycle instruction sequencer for a 9-bit-instruction CPU.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 leave IDLE/HALTED and begin at PC 0
//   instr_addr/instr_data instruction ROM address and combinational data
//   opcode/funcA/funcB    ALU control (opcode=111, funcB=0 outside EXEC)
//   rs_addr/rt_addr       register-file read selects
//   reg_we                one-cycle register-file write strobe
//   alu_overflow          ALU overflow flag, used as branch condition
//   mem_req/mem_we/mem_ready  data-memory handshake
//   done                  high while HALTED
module instr_ctrl
   import cpu_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   output logic [PcW-1:0]      instr_addr,
   input  logic [InstrW-1:0]   instr_data,
   output logic [OpW-1:0]      opcode,
   output logic [FuncAW-1:0]   funcA,
   output logic                funcB,
   output logic [RegAddrW-1:0] rs_addr,
   output logic [RegAddrW-1:0] rt_addr,
   output logic                reg_we,
   input  logic                alu_overflow,
   output logic                mem_req,
   output logic                mem_we,
   input  logic                mem_ready,
   output logic                done
);

   state_e              r_state;
   logic [PcW-1:0]      r_pc;
   logic [InstrW-1:0]   r_ir;
   logic                r_mem_req;
   logic                r_mem_we;
   logic                r_done;

   logic [OpW-1:0]      w_op;
   logic [FuncAW-1:0]   w_funca;
   logic                w_funcb;
   logic [OffsetW-1:0]  w_offset;
   logic                w_in_exec;
   logic                w_take;
   logic                w_exec_we;
   logic [PcW-1:0]      w_pc_next;

   assign w_op      = r_ir[8:6];
   assign w_funca   = r_ir[5:3];
   assign w_funcb   = r_ir[5];
   assign w_offset  = r_ir[4:0];
   assign w_in_exec = (r_state == StExec);
   assign w_take    = w_in_exec && (w_op == OpBranch) && (alu_overflow == w_funcb);
   assign w_exec_we = (w_op == OpAdd) || (w_op == OpDist) ||
                      ((w_op == OpFunc) && funca_writes(w_funca));

   pc_next u_pc_next (
      .i_pc      (r_pc),
      .i_offset  (w_offset),
      .i_branch  (w_take),
      .o_pc_next (w_pc_next)
   );

   // Register selects follow IR in every state so a LOAD still presents its
   // destination in MEM; opcode/funcB are parked outside EXEC to hold the flag.
   always_comb begin
      opcode  = OpHold;
      funcA   = '0;
      funcB   = FuncBOvfClr;
      rs_addr = '0;
      rt_addr = r_ir[2:0];
      reg_we  = 1'b0;
      case (w_op)
         OpFunc:   funcA   = w_funca;
         OpBranch: rt_addr = '0;
         default:  rs_addr = r_ir[5:3];
      endcase
      if (w_in_exec) begin
         opcode = w_op;
         funcB  = (w_op == OpBranch) ? w_funcb : FuncBOvfClr;
         reg_we = w_exec_we;
      end
      // LOAD write-back happens in the cycle the memory reports ready.
      if ((r_state == StMem) && mem_ready && !r_mem_we && !reset) reg_we = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= StIdle;
         r_pc      <= '0;
         r_ir      <= '0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= StFetch;
               end
            end
            StFetch: begin
               r_ir    <= instr_data;
               r_state <= StExec;
            end
            StExec: begin
               case (w_op)
                  OpLoad, OpStore: begin
                     r_mem_req <= 1'b1;
                     r_mem_we  <= (w_op == OpStore);
                     r_state   <= StMem;
                  end
                  OpFunc: begin
                     if (w_funca == FuncAHalt) begin
                        r_done  <= 1'b1;
                        r_state <= StHalted;
                     end else begin
                        r_pc    <= w_pc_next;
                        r_state <= StFetch;
                     end
                  end
                  default: begin
                     r_pc    <= w_pc_next;
                     r_state <= StFetch;
                  end
               endcase
            end
            StMem: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_pc      <= w_pc_next;
                  r_state   <= StFetch;
               end
            end
            StHalted: begin
               if (start) begin
                  r_pc    <= '0;
                  r_done  <= 1'b0;
                  r_state <= StFetch;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign instr_addr = r_pc;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign done       = r_done;

endmodule

// File: tb/tb_instr_ctrl.sv
// tb_instr_ctrl: directed scoreboard bench for instr_ctrl.
// Stimulus schedules expected output values for given cycles and expected
// reg_we / memory-handshake events into queues; a monitor compares them.
module tb_instr_ctrl;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] instr_addr;
   logic [8:0] instr_data;
   logic [2:0] opcode;
   logic [2:0] funcA;
   logic       funcB;
   logic [2:0] rs_addr;
   logic [2:0] rt_addr;
   logic       reg_we;
   logic       alu_overflow;
   logic       mem_req;
   logic       mem_we;
   logic       mem_ready;
   logic       done;

   logic [8:0] rom [256];
   assign instr_data = rom[instr_addr];

   instr_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .instr_addr   (instr_addr),
      .instr_data   (instr_data),
      .opcode       (opcode),
      .funcA        (funcA),
      .funcB        (funcB),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .reg_we       (reg_we),
      .alu_overflow (alu_overflow),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_ready    (mem_ready),
      .done         (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef enum int {FAddr, FOpc, FFa, FFb, FRs, FRt, FWe, FReq, FMwe, FDone} field_e;
   typedef struct { string name; field_e f; logic [7:0] val; int tgt; } chk_t;
   typedef struct { string name; logic [2:0] opc; logic [2:0] rt; } we_t;
   typedef struct { string name; logic we; } mem_t;

   chk_t chk_q[$];
   we_t  we_q[$];
   mem_t mem_q[$];

   int checks = 0;
   int errors = 0;
   logic final_req  = 1'b0;
   logic final_done = 1'b0;

   function automatic logic [7:0] sample(input field_e f);
      case (f)
         FAddr:   return instr_addr;
         FOpc:    return {5'b0, opcode};
         FFa:     return {5'b0, funcA};
         FFb:     return {7'b0, funcB};
         FRs:     return {5'b0, rs_addr};
         FRt:     return {5'b0, rt_addr};
         FWe:     return {7'b0, reg_we};
         FReq:    return {7'b0, mem_req};
         FMwe:    return {7'b0, mem_we};
         default: return {7'b0, done};
      endcase
   endfunction

   task automatic sched(input string n, input field_e f, input logic [7:0] v, input int t);
      chk_t e;
      e.name = n; e.f = f; e.val = v; e.tgt = t;
      chk_q.push_back(e);
   endtask

   task automatic push_we(input string n, input logic [2:0] opc, input logic [2:0] rt);
      we_t e;
      e.name = n; e.opc = opc; e.rt = rt;
      we_q.push_back(e);
   endtask

   task automatic push_mem(input string n, input logic we);
      mem_t e;
      e.name = n; e.we = we;
      mem_q.push_back(e);
   endtask

   task automatic sched_reset_vals(input string n, input int t);
      sched(n, FAddr, 8'h00, t); sched(n, FOpc, 8'h07, t); sched(n, FFa, 8'h00, t);
      sched(n, FFb, 8'h00, t);   sched(n, FRs, 8'h00, t);  sched(n, FRt, 8'h00, t);
      sched(n, FWe, 8'h00, t);   sched(n, FReq, 8'h00, t); sched(n, FMwe, 8'h00, t);
      sched(n, FDone, 8'h00, t);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic at(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic do_start(output int t0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic fill_rom();
      for (int k = 0; k < 256; k++) rom[k] = 9'h0C0;
   endtask

   // Monitor: scheduled field checks, reg_we events, memory completions.
   initial begin : mon
      int         i;
      logic [7:0] a;
      we_t        w;
      mem_t       m;
      forever begin
         @(negedge clock);
         i = 0;
         while (i < chk_q.size()) begin
            if (chk_q[i].tgt == cyc) begin
               checks++;
               a = sample(chk_q[i].f);
               if (a !== chk_q[i].val) begin
                  errors++;
                  $display("FAIL %s %s @%0d: got %0h want %0h", chk_q[i].name,
                           chk_q[i].f.name(), cyc, a, chk_q[i].val);
               end
               chk_q.delete(i);
            end else if (chk_q[i].tgt < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s stale check @%0d", chk_q[i].name, cyc);
               chk_q.delete(i);
            end else begin
               i++;
            end
         end
         if (reset === 1'b0 && reg_we === 1'b1) begin
            checks++;
            if (we_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_reg_we @%0d: got 1 want 0", cyc);
            end else begin
               w = we_q.pop_front();
               if ({opcode, rt_addr} !== {w.opc, w.rt}) begin
                  errors++;
                  $display("FAIL %s @%0d: got opc %0h rt %0h want opc %0h rt %0h", w.name,
                           cyc, opcode, rt_addr, w.opc, w.rt);
               end
            end
         end
         if (reset === 1'b0 && mem_req === 1'b1 && mem_ready === 1'b1) begin
            checks++;
            if (mem_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_mem_done @%0d: got handshake want none", cyc);
            end else begin
               m = mem_q.pop_front();
               if (mem_we !== m.we) begin
                  errors++;
                  $display("FAIL %s @%0d: got mem_we %0b want %0b", m.name, cyc, mem_we, m.we);
               end
            end
         end
         if (final_req && !final_done) begin
            checks += 3;
            if (chk_q.size() != 0) begin
               errors++;
               $display("FAIL chk_q_left: got %0d want 0", chk_q.size());
            end
            if (we_q.size() != 0) begin
               errors++;
               $display("FAIL reg_we_missing: got %0d pending want 0", we_q.size());
            end
            if (mem_q.size() != 0) begin
               errors++;
               $display("FAIL mem_missing: got %0d pending want 0", mem_q.size());
            end
            final_done = 1'b1;
         end
         if (cyc > 4000) begin
            errors++;
            $display("FAIL timeout: got cycle %0d want below 4000", cyc);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   initial begin : stim
      int t0;
      int t1;
      reset = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_overflow = 1'b0;
      fill_rom();

      // Reset state, then IDLE holds without start.
      step(1);
      sched_reset_vals("reset", cyc);
      step(1);
      reset = 1'b0;
      sched("idle_addr", FAddr, 8'h00, cyc + 3);
      sched("idle_opc", FOpc, 8'h07, cyc + 3);
      sched("idle_done", FDone, 8'h00, cyc + 3);
      step(4);

      // ADD r1,r2; HALT. start in EXEC is ignored; start in HALTED restarts.
      rom[0] = 9'h08A; rom[1] = 9'h1B8;
      do_start(t0);
      sched("t1_fetch_addr", FAddr, 8'h00, t0);     sched("t1_fetch_opc", FOpc, 8'h07, t0);
      sched("t1_fetch_we", FWe, 8'h00, t0);
      sched("t1_add_opc", FOpc, 8'h02, t0 + 1);     sched("t1_add_rs", FRs, 8'h01, t0 + 1);
      sched("t1_add_rt", FRt, 8'h02, t0 + 1);       sched("t1_add_we", FWe, 8'h01, t0 + 1);
      push_we("t1_add_we_ev", 3'd2, 3'd2);
      sched("t1_pc1", FAddr, 8'h01, t0 + 2);        sched("t1_fetch2_we", FWe, 8'h00, t0 + 2);
      sched("t1_halt_opc", FOpc, 8'h06, t0 + 3);    sched("t1_halt_fa", FFa, 8'h07, t0 + 3);
      sched("t1_halt_nodone", FDone, 8'h00, t0 + 3);
      sched("t1_done", FDone, 8'h01, t0 + 4);       sched("t1_halt_addr", FAddr, 8'h01, t0 + 4);
      sched("t1_done_hold", FDone, 8'h01, t0 + 5);  sched("t1_halt_addr2", FAddr, 8'h01, t0 + 5);
      sched("t1_restart_addr", FAddr, 8'h00, t0 + 6);
      sched("t1_restart_done", FDone, 8'h00, t0 + 6);
      sched("t1_rerun_opc", FOpc, 8'h02, t0 + 7);
      push_we("t1_rerun_we_ev", 3'd2, 3'd2);
      sched("t1_rerun_pc1", FAddr, 8'h01, t0 + 8);
      sched("t1_rerun_done", FDone, 8'h01, t0 + 10);
      at(t0 + 1); start = 1'b1; step(1); start = 1'b0;
      at(t0 + 5); start = 1'b1; step(1); start = 1'b0;
      at(t0 + 11);
      apply_reset();

      // Branch at PC 5 with offset -2: taken to 3, then not taken to 6.
      fill_rom();
      rom[1] = 9'h1AB; rom[3] = 9'h1B0; rom[4] = 9'h1A0; rom[5] = 9'h1FE; rom[6] = 9'h1B8;
      alu_overflow = 1'b1;
      do_start(t0);
      sched("t2_nop_opc", FOpc, 8'h03, t0 + 1);     sched("t2_nop_we", FWe, 8'h00, t0 + 1);
      sched("t2_fa5_we", FWe, 8'h01, t0 + 3);
      push_we("t2_fa5_we_ev", 3'd6, 3'd3);
      sched("t2_bof_opc", FOpc, 8'h07, t0 + 11);    sched("t2_bof_fb", FFb, 8'h01, t0 + 11);
      sched("t2_bof_we", FWe, 8'h00, t0 + 11);
      sched("t2_taken_addr", FAddr, 8'h03, t0 + 12);
      sched("t2_fetch_fb", FFb, 8'h00, t0 + 12);
      sched("t2_rsvd_fa", FFa, 8'h06, t0 + 13);     sched("t2_rsvd_we", FWe, 8'h00, t0 + 13);
      sched("t2_rsvd_pc", FAddr, 8'h04, t0 + 14);
      sched("t2_fa4_we", FWe, 8'h00, t0 + 15);      sched("t2_fa4_pc", FAddr, 8'h05, t0 + 16);
      sched("t2_bof2_fb", FFb, 8'h01, t0 + 17);
      sched("t2_ntaken_addr", FAddr, 8'h06, t0 + 18);
      sched("t2_done", FDone, 8'h01, t0 + 20);      sched("t2_halt_addr", FAddr, 8'h06, t0 + 20);
      at(t0 + 12); alu_overflow = 1'b0;
      at(t0 + 21);
      apply_reset();

      // Branch -1 from 0 reaches 8'hFF; ADD there wraps PC to 8'h00.
      fill_rom();
      rom[0] = 9'h1DF; rom[255] = 9'h09C;
      alu_overflow = 1'b0;
      do_start(t0);
      sched("t3_bof_fb", FFb, 8'h00, t0 + 1);
      sched("t3_addr_ff", FAddr, 8'hFF, t0 + 2);
      sched("t3_add_rs", FRs, 8'h03, t0 + 3);       sched("t3_add_we", FWe, 8'h01, t0 + 3);
      push_we("t3_add_we_ev", 3'd2, 3'd4);
      sched("t3_wrap_addr", FAddr, 8'h00, t0 + 4);
      at(t0 + 5);
      apply_reset();

      // LOAD with four wait states; mem_ready high outside MEM is ignored.
      fill_rom();
      rom[0] = 9'h02B; rom[1] = 9'h1B8;
      mem_ready = 1'b1;
      do_start(t0);
      sched("t4_exec_opc", FOpc, 8'h00, t0 + 1);    sched("t4_exec_rs", FRs, 8'h05, t0 + 1);
      sched("t4_exec_req", FReq, 8'h00, t0 + 1);    sched("t4_exec_we", FWe, 8'h00, t0 + 1);
      for (int k = 2; k <= 6; k++) begin
         sched("t4_mem_req", FReq, 8'h01, t0 + k);
         sched("t4_mem_we", FMwe, 8'h00, t0 + k);
         sched("t4_mem_opc", FOpc, 8'h07, t0 + k);
      end
      for (int k = 2; k <= 5; k++) sched("t4_wait_we", FWe, 8'h00, t0 + k);
      sched("t4_ready_we", FWe, 8'h01, t0 + 6);
      push_we("t4_load_we_ev", 3'd7, 3'd3);
      push_mem("t4_load_done", 1'b0);
      sched("t4_req_drop", FReq, 8'h00, t0 + 7);    sched("t4_pc1", FAddr, 8'h01, t0 + 7);
      sched("t4_done", FDone, 8'h01, t0 + 9);
      at(t0 + 2); mem_ready = 1'b0;
      at(t0 + 6); mem_ready = 1'b1;
      at(t0 + 10);
      mem_ready = 1'b0;
      apply_reset();

      // Reset mid-STORE wins over start and mem_ready; then restart from 0.
      fill_rom();
      rom[0] = 9'h051; rom[1] = 9'h1B8;
      do_start(t0);
      sched("t5_exec_opc", FOpc, 8'h01, t0 + 1);    sched("t5_exec_rs", FRs, 8'h02, t0 + 1);
      sched("t5_exec_mwe", FMwe, 8'h00, t0 + 1);
      sched("t5_mem_req", FReq, 8'h01, t0 + 2);     sched("t5_mem_we", FMwe, 8'h01, t0 + 2);
      sched("t5_mem_req2", FReq, 8'h01, t0 + 3);
      sched_reset_vals("t5_reset", t0 + 4);
      sched("t5_idle_opc", FOpc, 8'h07, t0 + 5);    sched("t5_idle_opc2", FOpc, 8'h07, t0 + 6);
      sched("t5_idle_req", FReq, 8'h00, t0 + 6);
      at(t0 + 3); reset = 1'b1; start = 1'b1; mem_ready = 1'b1;
      step(1);    reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
      at(t0 + 7);
      do_start(t1);
      sched("t5_refetch_addr", FAddr, 8'h00, t1);
      sched("t5_rerun_opc", FOpc, 8'h01, t1 + 1);
      sched("t5_rerun_req", FReq, 8'h01, t1 + 2);   sched("t5_rerun_mwe", FMwe, 8'h01, t1 + 2);
      push_mem("t5_store_done", 1'b1);
      sched("t5_after_req", FReq, 8'h00, t1 + 3);   sched("t5_after_mwe", FMwe, 8'h00, t1 + 3);
      sched("t5_after_pc", FAddr, 8'h01, t1 + 3);
      sched("t5_done", FDone, 8'h01, t1 + 5);
      at(t1 + 2); mem_ready = 1'b1;
      at(t1 + 3); mem_ready = 1'b0;
      at(t1 + 6);

      final_req = 1'b1;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
